// File: rtl/tt_dfd_skid_buffer.sv
// Two-entry valid/ready register stage (output register + skid register).
// in_ready depends only on registered state, rst and flush, never on out_ready.
module tt_dfd_skid_buffer #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter bit          BYPASS      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

    if (BYPASS) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk, rst, flush};

        assign out_valid = in_valid;
        assign out_data  = in_data;
        assign in_ready  = out_ready;
        assign occupancy = 2'd0;
    end else begin : g_reg
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            BUSY  = 2'd1,
            FULL  = 2'd2
        } state_t;

        state_t           state;
        state_t           state_nxt;
        logic [WIDTH-1:0] skid;
        logic             accept;
        logic             take;
        logic             load_out_in;
        logic             load_out_skid;
        logic             load_skid;

        assign in_ready  = !rst && !flush && (state != FULL);
        assign out_valid = (state != EMPTY);
        assign occupancy = state;
        assign accept    = in_valid && in_ready;
        assign take      = out_valid && out_ready;

        always_comb begin
            state_nxt     = state;
            load_out_in   = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt   = BUSY;
                        load_out_in = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && take) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (take) begin
                        state_nxt     = BUSY;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
            // A take during flush is a final delivery; out_data must keep the delivered beat.
            if (flush) begin
                state_nxt     = EMPTY;
                load_out_in   = 1'b0;
                load_out_skid = 1'b0;
                load_skid     = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state    <= EMPTY;
                out_data <= RST_DATA;
                skid     <= RST_DATA;
            end else begin
                state <= state_nxt;
                if (load_out_in) begin
                    out_data <= in_data;
                end else if (load_out_skid) begin
                    out_data <= skid;
                end
                if (load_skid) begin
                    skid <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_dfd_skid_buffer.sv
// Directed and randomised checks of tt_dfd_skid_buffer (registered and bypass builds).
module tb_tt_dfd_skid_buffer;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [1:0] occupancy;

    logic       b_rst;
    logic       b_flush;
    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    logic       b_out_ready;
    logic [1:0] b_occupancy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    tt_dfd_skid_buffer #(
        .WIDTH      (8),
        .RESET_VALUE(32'h5A),
        .BYPASS     (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy)
    );

    tt_dfd_skid_buffer #(
        .WIDTH      (8),
        .RESET_VALUE(32'h5A),
        .BYPASS     (1'b1)
    ) dut_bypass (
        .clk      (clk),
        .rst      (b_rst),
        .flush    (b_flush),
        .in_valid (b_in_valid),
        .in_data  (b_in_data),
        .in_ready (b_in_ready),
        .out_valid(b_out_valid),
        .out_data (b_out_data),
        .out_ready(b_out_ready),
        .occupancy(b_occupancy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer rule: a stalled beat must be held unchanged until accepted.
    logic       pend_v = 1'b0;
    logic [7:0] pend_d = '0;
    always @(posedge clk) begin
        if (pend_v) check("producer_hold", {23'd0, in_valid, in_data}, {23'd0, 1'b1, pend_d});
        pend_v <= in_valid && !in_ready;
        pend_d <= in_data;
    end

    logic [7:0]  sb[$];
    logic [7:0]  exp_d;
    logic        acc;
    logic        tk;
    logic        r0;
    int unsigned beats;
    int unsigned cyc;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        b_rst = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset held 3 cycles with a beat waiting at the producer
        #1;
        check("rst_in_ready_comb", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_data", {24'd0, out_data}, 32'h5A);
            check("rst_occupancy", {30'd0, occupancy}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("first_beat_valid", {31'd0, out_valid}, 32'd1);
        check("first_beat_data", {24'd0, out_data}, 32'hAA);
        check("first_beat_occ", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("empty_hold_data", {24'd0, out_data}, 32'hAA);
        check("drain_occ", {30'd0, occupancy}, 32'd0);

        // Streaming 0x01..0x10 at full rate
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            #1;
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            check("stream_data", {24'd0, out_data}, 32'(i));
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_occ", {30'd0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", {30'd0, occupancy}, 32'd0);

        // Back-pressure: 0x01, 0x02 accepted, 0x03 stalls at producer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h01; tick();
        check("bp_occ1", {30'd0, occupancy}, 32'd1);
        in_data = 8'h02; tick();
        check("bp_occ2", {30'd0, occupancy}, 32'd2);
        in_data = 8'h03;
        #1;
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_head_data", {24'd0, out_data}, 32'h01);
        tick();
        check("bp_stall_data", {24'd0, out_data}, 32'h01);
        check("bp_stall_occ", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1;
        tick();
        check("bp_second_data", {24'd0, out_data}, 32'h02);
        check("bp_second_occ", {30'd0, occupancy}, 32'd1);
        tick();
        check("bp_third_data", {24'd0, out_data}, 32'h03);
        check("bp_third_occ", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("bp_end_occ", {30'd0, occupancy}, 32'd0);

        // Flush in FULL with a take; the concurrent accept must not happen
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        check("fl_full_occ", {30'd0, occupancy}, 32'd2);
        flush = 1'b1; out_ready = 1'b1; in_data = 8'h33;
        #1;
        check("fl_in_ready", {31'd0, in_ready}, 32'd0);
        check("fl_final_valid", {31'd0, out_valid}, 32'd1);
        check("fl_final_data", {24'd0, out_data}, 32'h11);
        tick();
        flush = 1'b0;
        #1;
        check("fl_after_valid", {31'd0, out_valid}, 32'd0);
        check("fl_after_occ", {30'd0, occupancy}, 32'd0);
        check("fl_keep_data", {24'd0, out_data}, 32'h11);
        tick();
        check("fl_next_beat_data", {24'd0, out_data}, 32'h33);
        check("fl_next_beat_occ", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("fl_skid_gone", {31'd0, out_valid}, 32'd0);

        // Reset mid-transfer from FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h44; tick();
        in_data = 8'h55; tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_occ", {30'd0, occupancy}, 32'd0);
        check("midrst_data", {24'd0, out_data}, 32'h5A);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);

        // Random traffic against a queue scoreboard
        beats = 0; cyc = 0; acc = 1'b0;
        while (beats < 10000 && cyc < 60000) begin
            if (!(in_valid && !acc)) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (cyc % 500 == 0) begin
                r0 = in_ready;
                out_ready = ~out_ready;
                #1;
                check("rand_ready_indep", {31'd0, in_ready}, {31'd0, r0});
                out_ready = ~out_ready;
                #1;
            end
            check("rand_occ_model", {30'd0, occupancy}, 32'(sb.size()));
            check("rand_valid_model", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            acc = in_valid && in_ready;
            tk  = out_valid && out_ready;
            if (tk && sb.size() != 0) begin
                exp_d = sb.pop_front();
                check("rand_order", {24'd0, out_data}, {24'd0, exp_d});
                beats++;
            end
            if (acc) sb.push_back(in_data);
            tick();
            cyc++;
        end
        check("rand_beats_done", beats, 32'd10000);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();

        // Bypass: outputs follow inputs in the same cycle; rst/flush ignored
        for (int i = 0; i < 8; i++) begin
            b_in_valid  = i[0];
            b_out_ready = i[1];
            b_rst       = i[2];
            b_flush     = ~i[0];
            b_in_data   = 8'(8'h30 + i * 7);
            #1;
            check("byp_out_valid", {31'd0, b_out_valid}, 32'(i % 2));
            check("byp_in_ready", {31'd0, b_in_ready}, 32'((i / 2) % 2));
            check("byp_out_data", {24'd0, b_out_data}, 32'(8'h30 + i * 7));
            check("byp_occ", {30'd0, b_occupancy}, 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
